seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the combinational 32-bit ALU: same 3-bit opcode space and zero flag, plus carry/overflow/negative flags.
- Single-cycle ops (add/sub/logic/slt) complete in 1 cycle; multiply and shift-left are iterative, one bit per cycle.
- Valid/ready on both sides lets it sit between the decode and writeback stages of the datapath.
- Executes one operation at a time; no overlap.

Parameters:
- WIDTH, 32, operand/result width; legal range 4..64, power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- data_1  in  WIDTH  operand A
- data_2  in  WIDTH  operand B (shift amount = data_2[SHW-1:0])
- alu_control  in  3  opcode
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero_flag  out  1  result == 0
- carry_flag  out  1  see arithmetic rules
- overflow_flag  out  1  signed overflow
- negative_flag  out  1  result[WIDTH-1]
- busy  out  1  high in BUSY or DONE

Behaviour:
- Opcodes:
  - 000 add
  - 001 sub (data_1 - data_2)
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt (signed; result 1 or 0)
  - 110 sll (iterative)
  - 111 mul (unsigned shift-add, iterative; result = low WIDTH bits)
- Reset (synchronous): state = IDLE; in_ready = 1; out_valid = 0; result = 0; all flags = 0; busy = 0; iteration counter = 0. Reset asserted mid-BUSY or mid-DONE aborts the operation; the result is discarded.
- Accept: in IDLE with in_valid = 1. Operands and opcode are latched on that edge, and in_ready drops the following cycle.
- States:
  - IDLE
    - Accept with opcode 000-101: compute, register result and flags, go to DONE.
    - Accept with sll and shamt = 0: DONE with result = data_1.
    - Accept with sll and shamt > 0: go to BUSY, counter = shamt.
    - Accept with mul: go to BUSY, counter = WIDTH.
  - BUSY: one bit per cycle; counter decrements. When the counter reaches 1, the final value is registered and the state moves to DONE.
    - sll: accumulator <<= 1.
    - mul: if multiplier LSB, add the shifted multiplicand into a 2*WIDTH-bit accumulator; shift the multiplier right.
  - DONE: out_valid = 1; result and flags stable. On out_ready = 1, go to IDLE; out_valid drops the next cycle.
- Latency (accept edge to first out_valid cycle):
  - single-cycle ops: 1
  - sll: max(shamt, 0) + 1
  - mul: WIDTH + 1
- Throughput: a back-to-back request is accepted at the earliest 1 cycle after the DONE handshake, i.e. in the cycle in_ready is high again.
- in_valid during BUSY/DONE is ignored; the requester must hold it until in_ready.
- out_ready held high while not DONE has no effect.
- Flags (all registered with result):
  - add: carry = carry-out of bit WIDTH-1; overflow = operands same sign and result sign differs.
  - sub: carry = borrow (data_1 < data_2 unsigned); overflow = operand signs differ and result sign differs from data_1.
  - mul: carry = 1 iff upper WIDTH bits of the full product are nonzero; overflow = 0.
  - sll: carry = last bit shifted out (0 if shamt = 0); overflow = 0.
  - logic, slt: carry = 0, overflow = 0.
  - zero and negative are always derived from the final result.

Test Plan:
- Reset then add 1+2 (WIDTH=32): accepted, out_valid 1 cycle later; result = 3, zero = 0, carry = 0.
- sub 3-3 -> result 0, zero = 1, carry = 0; sub 0-1 -> 0xFFFFFFFF, negative = 1, carry = 1.
- Overflow and slt: add 0x7FFFFFFF+1 -> 0x80000000, overflow = 1, negative = 1. slt 0xFFFFFFFF,1 -> 1.
- Iterative ops:
  - mul 0x10000 * 0x10000 -> out_valid at cycle 33; result 0, carry = 1, zero = 1.
  - mul 7*6 -> 42.
  - sll 1,shamt=5 -> 32 after 6 cycles.
  - sll shamt=0 -> 1 cycle.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> result stable and in_ready = 0 throughout; a pulsed in_valid is ignored. Release -> next op accepted 1 cycle later.
- Reset at cycle 10 of a mul -> next cycle out_valid = 0, result = 0, in_ready = 1. A new add 4+2 then returns 6 normally.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/slt, iterative sll and shift-add multiply.
// Holds one operation at a time; result and flags are registered and held through DONE.
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             negative_flag,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d, carry_q, carry_d;
  logic                 ovf_q, ovf_d, neg_q, neg_d;
  logic                 load;

  logic [WIDTH:0]       sum, diff;
  logic [2*WIDTH-1:0]   acc_next;

  assign sum  = {1'b0, data_1} + {1'b0, data_2};
  assign diff = {1'b0, data_1} - {1'b0, data_2};
  assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = alu_control;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          load    = 1'b1;
          state_d = StDone;
          unique case (alu_control)
            3'b000: begin
              result_d = sum[WIDTH-1:0];
              carry_d  = sum[WIDTH];
              ovf_d    = (data_1[WIDTH-1] == data_2[WIDTH-1]) &&
                         (sum[WIDTH-1] != data_1[WIDTH-1]);
            end
            3'b001: begin
              result_d = diff[WIDTH-1:0];
              carry_d  = diff[WIDTH];
              ovf_d    = (data_1[WIDTH-1] != data_2[WIDTH-1]) &&
                         (diff[WIDTH-1] != data_1[WIDTH-1]);
            end
            3'b010: result_d = data_1 & data_2;
            3'b011: result_d = data_1 | data_2;
            3'b100: result_d = data_1 ^ data_2;
            3'b101: result_d = WIDTH'($signed(data_1) < $signed(data_2));
            3'b110: begin
              if (data_2[SHW-1:0] == '0) begin
                result_d = data_1;
              end else begin
                load    = 1'b0;
                acc_d   = {{WIDTH{1'b0}}, data_1};
                cnt_d   = CW'(data_2[SHW-1:0]);
                state_d = StBusy;
              end
            end
            default: begin
              load     = 1'b0;
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, data_1};
              mplier_d = data_2;
              cnt_d    = CW'(WIDTH);
              state_d  = StBusy;
            end
          endcase
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == 3'b111) begin
          acc_d    = acc_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == CW'(1)) begin
            result_d = acc_next[WIDTH-1:0];
            carry_d  = |acc_next[2*WIDTH-1:WIDTH];
            load     = 1'b1;
            state_d  = StDone;
          end
        end else begin
          acc_d = acc_q << 1;
          if (cnt_q == CW'(1)) begin
            // Bit leaving the top on the final shift is the carry
            result_d = {acc_q[WIDTH-2:0], 1'b0};
            carry_d  = acc_q[WIDTH-1];
            load     = 1'b1;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      zero_d = (result_d == '0);
      neg_d  = result_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign out_valid     = (state_q == StDone);
  assign busy          = (state_q != StIdle);
  assign result        = result_q;
  assign zero_flag     = zero_q;
  assign carry_flag    = carry_q;
  assign overflow_flag = ovf_q;
  assign negative_flag = neg_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed corner cases plus random operations, checked every cycle
// against an arithmetic model of each opcode's result, flags and latency.
module tb_seq_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  data_1, data_2, result;
  logic [2:0]    alu_control;
  logic          zero_flag, carry_flag, overflow_flag, negative_flag;

  seq_alu #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_1        (data_1),
    .data_2        (data_2),
    .alu_control   (alu_control),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .negative_flag (negative_flag),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z, c, v, n;
    int           lat;
    int           t;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   cyc = 0;
  bit   first = 1'b1;
  bit   rst_chk = 1'b0;
  logic [W-1:0] last_res;
  logic         last_c, last_z, last_v, last_n;
  int           last_lat;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t m;
    logic [63:0] full;
    int sh;
    m.c = 1'b0; m.v = 1'b0; m.lat = 1; m.t = 0;
    case (op)
      3'd0: begin
        full  = {32'b0, a} + {32'b0, b};
        m.res = full[31:0];
        m.c   = full[32];
        m.v   = (a[31] == b[31]) && (m.res[31] != a[31]);
      end
      3'd1: begin
        m.res = a - b;
        m.c   = (a < b);
        m.v   = (a[31] != b[31]) && (m.res[31] != a[31]);
      end
      3'd2: m.res = a & b;
      3'd3: m.res = a | b;
      3'd4: m.res = a ^ b;
      3'd5: m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: begin
        sh    = int'(b[4:0]);
        full  = {32'b0, a} << sh;
        m.res = full[31:0];
        m.c   = full[32];
        m.lat = sh + 1;
      end
      default: begin
        full  = {32'b0, a} * {32'b0, b};
        m.res = full[31:0];
        m.c   = |full[63:32];
        m.lat = W + 1;
      end
    endcase
    m.z = (m.res == 0);
    m.n = m.res[31];
    return m;
  endfunction

  // Compare process: outputs seen here reflect the previous rising edge; inputs seen here
  // are what the next rising edge will sample.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_chk) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {zero_flag, carry_flag, overflow_flag, negative_flag}, 0);
    end
    rst_chk = rst;
    if (rst) begin
      q.delete();
      first = 1'b1;
    end else begin
      chk("ready_vs_busy", in_ready, !busy);
      if (out_valid) begin
        chk("ready_in_done", in_ready, 0);
        if (q.size() == 0) begin
          chk("spurious_valid", out_valid, 0);
        end else begin
          e = q[0];
          chk("result", result, e.res);
          chk("zero", zero_flag, e.z);
          chk("carry", carry_flag, e.c);
          chk("overflow", overflow_flag, e.v);
          chk("negative", negative_flag, e.n);
          if (first) begin
            chk("latency", cyc - e.t, e.lat);
            last_res = result; last_c = carry_flag; last_z = zero_flag;
            last_v = overflow_flag; last_n = negative_flag; last_lat = cyc - e.t;
            first = 1'b0;
          end
          if (out_ready) begin
            void'(q.pop_front());
            first = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(alu_control, data_1, data_2);
        e.t = cyc;
        q.push_back(e);
      end
    end
  end

  // Drivers run at posedge+1.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    in_valid = 1'b1; alu_control = op; data_1 = a; data_2 = b;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; data_1 = $urandom; data_2 = $urandom; alu_control = 3'($urandom);
  endtask

  task automatic finish_op(input int hold, input bit pulse);
    int n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    if (!out_valid) chk("done_timeout", out_valid, 1);
    if (!out_ready) begin
      @(posedge clk); #1;
      for (int i = 0; i < hold; i++) begin
        in_valid = pulse && (i == 4);
        if (in_valid) alu_control = 3'b111;
        @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    chk("ready_after_done", in_ready, 1);
  endtask

  task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(op, a, b);
    finish_op(0, 1'b0);
  endtask

  task automatic expect_last(input string name, input logic [W-1:0] r, input logic c,
                             input logic z, input int lat);
    chk({name, "_res"}, last_res, r);
    chk({name, "_carry"}, last_c, c);
    chk({name, "_zero"}, last_z, z);
    chk({name, "_lat"}, last_lat, lat);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    exp_t m;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    data_1 = '0; data_2 = '0; alu_control = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed values pinning the model
    m = model(3'd7, 32'd7, 32'd6);            chk("model_mul", m.res, 42);
    m = model(3'd6, 32'd1, 32'd5);            chk("model_sll", {m.res, 8'(m.lat)}, {32'd32, 8'd6});
    m = model(3'd1, 32'd0, 32'd1);            chk("model_sub", {m.res, m.c, m.n}, {32'hFFFF_FFFF, 2'b11});
    m = model(3'd0, 32'h7FFF_FFFF, 32'd1);    chk("model_ovf", {m.v, m.n}, 2'b11);

    run(3'd0, 32'd1, 32'd2);                  expect_last("add12", 32'd3, 0, 0, 1);
    run(3'd1, 32'd3, 32'd3);                  expect_last("sub33", 32'd0, 0, 1, 1);
    run(3'd1, 32'd0, 32'd1);                  expect_last("sub01", 32'hFFFF_FFFF, 1, 0, 1);
    chk("sub01_neg", last_n, 1);
    run(3'd0, 32'h7FFF_FFFF, 32'd1);          expect_last("addovf", 32'h8000_0000, 0, 0, 1);
    chk("addovf_v", {last_v, last_n}, 2'b11);
    run(3'd5, 32'hFFFF_FFFF, 32'd1);          expect_last("slt", 32'd1, 0, 0, 1);
    run(3'd7, 32'h0001_0000, 32'h0001_0000);  expect_last("mulbig", 32'd0, 1, 1, 33);
    run(3'd7, 32'd7, 32'd6);                  expect_last("mul76", 32'd42, 0, 0, 33);
    run(3'd6, 32'd1, 32'd5);                  expect_last("sll5", 32'd32, 0, 0, 6);
    run(3'd6, 32'h1234, 32'd32);              expect_last("sll0", 32'h1234, 0, 0, 1);
    run(3'd6, 32'hC000_0001, 32'd1);          expect_last("sllc", 32'h8000_0002, 1, 0, 2);

    // Backpressure with an ignored request pulse, then back-to-back accept
    start_op(3'd0, 32'd5, 32'd5);
    finish_op(10, 1'b1);
    run(3'd3, 32'hF0, 32'h0F);                expect_last("or_after_bp", 32'hFF, 0, 0, 1);

    // Reset in the middle of a multiply
    start_op(3'd7, 32'd123, 32'd456);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_in_ready", in_ready, 1);
    run(3'd0, 32'd4, 32'd2);                  expect_last("add42", 32'd6, 0, 0, 1);

    for (int i = 0; i < 150; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      start_op(3'($urandom_range(0, 7)), pick(), pick());
      finish_op($urandom_range(0, 3), 1'b0);
    end
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
